// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single shared MemoryController port: fetch, speculative loads
// and committed stores take turns, one latched command at a time, with flush-safe draining.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_ready,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_data,
  input  logic        mc_ready,
  input  logic [31:0] mc_res
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  typedef enum logic [1:0] {G_IF, G_LD, G_ST} grant_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nx;
  grant_t      grant, grant_nx;
  logic [3:0]  starve_cnt, starve_nx;
  logic        mc_valid_nx, mc_wr_nx;
  logic [31:0] addr_nx, data_nx;
  logic [2:0]  len_nx;
  logic        take, fin;
  grant_t      pick;

  // Requesters read mc_res directly; it is not routed through this block.
  logic res_unused;
  assign res_unused = ^mc_res;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? v : v + 4'd1;
  endfunction

  // Completion pulses are combinational so the requester sees them alongside mc_res.
  assign fin      = rdy_in && mc_ready && (state == BUSY);
  assign if_ready = fin && (grant == G_IF) && !rob_clear;
  assign ld_ready = fin && (grant == G_LD) && !rob_clear;
  assign st_done  = fin && (grant == G_ST);

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    starve_nx   = starve_cnt;
    mc_valid_nx = mc_valid;
    mc_wr_nx    = mc_wr;
    addr_nx     = mc_addr;
    len_nx      = mc_len;
    data_nx     = mc_data;
    take        = 1'b0;
    pick        = G_IF;

    if (rdy_in) begin
      case (state)
        IDLE: begin
          if (!if_valid) starve_nx = '0;
          if (!rob_clear) begin
            if (st_valid) begin
              take = 1'b1; pick = G_ST;
            end else if (if_valid && starve_cnt == LIMIT) begin
              take = 1'b1; pick = G_IF;
            end else if (ld_valid) begin
              take = 1'b1; pick = G_LD;
            end else if (if_valid) begin
              take = 1'b1; pick = G_IF;
            end
          end
          if (take) begin
            state_nx    = BUSY;
            grant_nx    = pick;
            mc_valid_nx = 1'b1;
            mc_wr_nx    = (pick == G_ST);
            case (pick)
              G_ST:    begin addr_nx = st_addr; len_nx = st_size; data_nx = st_data; end
              G_LD:    begin addr_nx = ld_addr; len_nx = ld_size; data_nx = '0; end
              default: begin addr_nx = if_addr; len_nx = 3'b010; data_nx = '0; end
            endcase
            if (pick == G_IF)  starve_nx = '0;
            else if (if_valid) starve_nx = sat_inc(starve_cnt);
          end
        end
        BUSY: begin
          if (mc_ready) begin
            state_nx    = IDLE;
            mc_valid_nx = 1'b0;
          end else if (rob_clear && grant != G_ST) begin
            state_nx = DRAIN;
          end
        end
        DRAIN: begin
          if (mc_ready) begin
            state_nx    = IDLE;
            mc_valid_nx = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Command register stage: reset clears everything since the controller aborts too.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      grant      <= G_IF;
      starve_cnt <= '0;
      mc_valid   <= 1'b0;
      mc_wr      <= 1'b0;
      mc_addr    <= '0;
      mc_len     <= '0;
      mc_data    <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      starve_cnt <= starve_nx;
      mc_valid   <= mc_valid_nx;
      mc_wr      <= mc_wr_nx;
      mc_addr    <= addr_nx;
      mc_len     <= len_nx;
      mc_data    <= data_nx;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single shared MemoryController port, sitting between the front end and the load/store path. Three requesters share it: instruction fetch, speculative loads and committed stores. The block grants one transaction at a time and latches its command. It drives the controller's valid/ready handshake, returns results to the granted requester, and keeps the memory port safe across ROB flushes.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced (1..15).
- clk_in  input  1  system clock
- rst_n_in  input  1  one clock; reset is synchronous and active-low
- rdy_in  input  1  global ready; low freezes the block
- rob_clear  input  1  flush pulse; cancels speculative (fetch/load) work
- if_valid  input  1  fetch request, held until if_ready
- if_addr  input  32  fetch address
- if_ready  output  1  one-cycle pulse; mc_res is the fetched word
- ld_valid  input  1  load request, held until ld_ready
- ld_addr  input  32  load address
- ld_size  input  3  [1:0] 0 byte / 1 half / 2 word; [2] signed
- ld_ready  output  1  one-cycle pulse; mc_res is the load result
- st_valid  input  1  store request, held until st_done
- st_addr  input  32  store address
- st_size  input  3  same encoding as ld_size
- st_data  input  32  store data
- st_done  output  1  one-cycle pulse on store completion
- mc_valid  output  1  command valid to MemoryController, level-held
- mc_wr  output  1  1 = write
- mc_addr  output  32  latched address
- mc_len  output  3  latched size; fetch uses 3'b010
- mc_data  output  32  latched store data
- mc_ready  input  1  one-cycle completion pulse from controller
- mc_res  input  32  controller result, valid with mc_ready

## Operation
- States are IDLE, BUSY and DRAIN. The grant register holds IF, LD or ST.
- IDLE with no rob_clear: choose one requester, with the first matching rule winning:
  - st_valid;
  - if_valid and starve_cnt == STARVE_LIMIT;
  - ld_valid;
  - if_valid.
- On a grant: latch addr, len and data (st_data for stores, otherwise 0). Set mc_wr = (grant==ST), mc_valid = 1, and go to BUSY.
- starve_cnt:
  - cleared on every IF grant;
  - cleared on any cycle in IDLE with if_valid low;
  - incremented, saturating at STARVE_LIMIT, on an LD or ST grant made while if_valid is high.
- BUSY: hold mc_valid and all latched command fields stable. On mc_ready:
  - pulse the ready output matching the grant (if_ready, ld_ready or st_done);
  - clear mc_valid;
  - go to IDLE.
- rob_clear in BUSY with grant IF or LD: go to DRAIN.
- rob_clear in BUSY with grant ST: ignored. Committed stores always complete, and st_done still pulses.
- DRAIN: keep mc_valid high with the command unchanged until mc_ready. Then clear mc_valid and go to IDLE with no ready pulse. Requesters have already dropped their valids.
- rob_clear in IDLE: no grant that cycle, for any requester.
- rob_clear in DRAIN: no effect.
- rob_clear and mc_ready in the same BUSY cycle with grant IF or LD: the result is discarded, there is no ready pulse, and the state goes to IDLE.
- rdy_in low: state, latches and counter hold; mc_valid holds. mc_ready is ignored, and if_ready, ld_ready and st_done are forced to 0.
- rst_n_in low: the block goes to IDLE immediately, aborting any transaction in flight (the controller shares the reset). This takes precedence over everything else.

## Timing
- Reset values:
  - mc_valid, mc_wr = 0; mc_addr, mc_data = 0; mc_len = 0;
  - if_ready, ld_ready, st_done = 0;
  - state IDLE, starve_cnt 0, grant IF.
- Grant latency: a request seen in IDLE at edge t has mc_valid = 1 from t+1.
- Completion: the ready pulse is combinational from mc_ready (gated by state, grant, rob_clear and rdy_in), in the same cycle as mc_ready. mc_res passes straight through.
- After mc_ready, mc_valid is 0 for at least one cycle (the IDLE cycle). Back-to-back transactions are therefore spaced by at least one idle cycle.
- Requester-side fields may change after the grant without affecting the transaction in flight.
- Exactly one ready pulse per granted, non-flushed transaction; never a pulse for a requester that was not granted.

## Test plan
- Fetch only: if_valid at 0x100, mc_ready with mc_res=0x00000013 three cycles after mc_valid -> mc_len=3'b010, mc_wr=0, if_ready pulses once with 0x13, mc_valid low the next cycle.
- Contention: if_valid, ld_valid and st_valid all high in the same cycle (st 0x2000 ← 0xDEADBEEF, size 2) -> grant order ST, LD, IF. mc_wr=1 only for ST, and mc_data=0xDEADBEEF is held throughout BUSY.
- Starvation with STARVE_LIMIT=4: if_valid held while ld_valid is re-asserted continuously -> exactly 4 LD grants, then an IF grant, then starve_cnt=0.
- Flush: rob_clear while an LD at 0x3000 is BUSY -> DRAIN, mc_valid held until mc_ready, no ld_ready. Same stimulus on an ST -> st_done pulses normally.
- Pause and reset: rdy_in low for 5 cycles mid-BUSY with mc_ready pulsed during the pause -> no pulse, state and fields unchanged. rst_n_in low mid-BUSY -> all outputs at reset values on the next edge.
